// File: rtl/freq_pkg.sv
// Shared constants and helpers for the bin-index to frequency conversion path.
// Latency: n/a (package: constant functions and a combinational rounding helper).
// Backpressure: n/a.
package freq_pkg;

    localparam int DEF_FS_HZ     = 44100;
    localparam int DEF_FFT_SIZE  = 2048;
    localparam int DEF_FRAC_BITS = 12;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(88201) = 17.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Hz per bin in Q.frac: (fs << frac) / fft, evaluated in 64 bits so the
    // shift cannot overflow before the divide.
    function automatic int calc_scale(input int fs, input int fft, input int frac);
        longint s;
        s = (longint'(fs) << frac) / longint'(fft);
        return int'(s);
    endfunction

    // Q.frac -> integer, rounded half-up.
    function automatic logic [63:0] round_hz(input logic [63:0] p, input int frac);
        if (frac <= 0) begin
            return p;
        end
        return (p + (64'd1 << (frac - 1))) >> frac;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, grant index and any-grant flag from a request vector.
// Latency: combinational grant; the priority pointer updates on the clock edge of a grant.
// Backpressure: no grant is issued while adv_i is low, and the pointer then holds.
// Ports: clk, reset (async, active-high), req_i, adv_i -> gnt_o, gnt_idx_o, gnt_any_o.
module rr_arbiter
    import freq_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    localparam int CH_WIDTH = clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic                adv_i,
    output logic [NUM_CH-1:0]   gnt_o,
    output logic [CH_WIDTH-1:0] gnt_idx_o,
    output logic                gnt_any_o
);

    logic [CH_WIDTH-1:0] ptr_q;
    logic [CH_WIDTH-1:0] ptr_d;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int c;
        c         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        if (adv_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                c = (int'(ptr_q) + i) % NUM_CH;
                if (!gnt_any_o && req_i[c]) begin
                    gnt_any_o = 1'b1;
                    gnt_idx_o = CH_WIDTH'(c);
                end
            end
        end
        if (gnt_any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_o) begin
            if (gnt_idx_o == CH_WIDTH'(NUM_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_o + CH_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/peak_freq_arbiter.sv
// Shares one index*SCALE multiplier among NUM_CH peak channels; results tagged with channel ID.
// Latency: 2 cycles from capture to freq_valid_out with no contention; one result per cycle.
// Backpressure: freq_ready_in low with a valid result freezes both stages and stops granting;
//   pending requests stay buffered (a second strobe overwrites and sets the sticky overrun flag).
// Ports: clk, reset (async, active-high), flush (sync clear), peak_valid_in/peak_index_in (per
//   channel strobe + packed index), freq_out/freq_ch_out/freq_valid_out/freq_ready_in (result
//   handshake), overrun_out (sticky per-channel overwrite flags).
// Build option: FREQ_ROUND_EN outputs integer Hz rounded half-up instead of the raw Q.FRAC_BITS value.
module peak_freq_arbiter
    import freq_pkg::*;
#(
    parameter  int NUM_CH           = 4,
    parameter  int INDEX_WIDTH      = 11,
    parameter  int SAMPLING_RATE_HZ = DEF_FS_HZ,
    parameter  int FFT_SIZE         = DEF_FFT_SIZE,
    parameter  int FRAC_BITS        = DEF_FRAC_BITS,
    parameter  int FREQ_WIDTH       = 28,
    localparam int CH_WIDTH         = clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_CH-1:0]             peak_valid_in,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] peak_index_in,
    output logic [FREQ_WIDTH-1:0]         freq_out,
    output logic [CH_WIDTH-1:0]           freq_ch_out,
    output logic                          freq_valid_out,
    input  logic                          freq_ready_in,
    output logic [NUM_CH-1:0]             overrun_out
);

    localparam int SCALE  = calc_scale(SAMPLING_RATE_HZ, FFT_SIZE, FRAC_BITS);
    localparam int PROD_W = INDEX_WIDTH + clog2(SCALE + 1);

    // The product must be exact in FREQ_WIDTH bits.
    if (PROD_W > FREQ_WIDTH) begin : g_width_check
        $error("peak_freq_arbiter: INDEX_WIDTH + clog2(SCALE+1) exceeds FREQ_WIDTH");
    end

    logic [NUM_CH-1:0]      pend_q, pend_d;
    logic [NUM_CH-1:0]      ovr_q, ovr_d;
    logic [INDEX_WIDTH-1:0] idx_q [NUM_CH];
    logic [INDEX_WIDTH-1:0] idx_d [NUM_CH];

    logic                   s1_vld_q, s1_vld_d;
    logic [INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
    logic [CH_WIDTH-1:0]    s1_ch_q, s1_ch_d;

    logic                   out_vld_q, out_vld_d;
    logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
    logic [CH_WIDTH-1:0]    ch_q, ch_d;

    logic                   adv;
    logic [NUM_CH-1:0]      gnt;
    logic [CH_WIDTH-1:0]    gnt_idx;
    logic                   gnt_any;
    logic [PROD_W-1:0]      prod;
    logic [FREQ_WIDTH-1:0]  freq_calc;

    assign adv = !out_vld_q || freq_ready_in;

    // Gating with flush keeps the round-robin pointer where it was across a flush.
    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     (pend_q),
        .adv_i     (adv && !flush),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign prod = PROD_W'(s1_idx_q) * PROD_W'(SCALE);

`ifdef FREQ_ROUND_EN
    assign freq_calc = FREQ_WIDTH'(round_hz(64'(prod), FRAC_BITS));
`else
    assign freq_calc = FREQ_WIDTH'(prod);
`endif

    always_comb begin
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        idx_d     = idx_q;
        s1_vld_d  = s1_vld_q;
        s1_idx_d  = s1_idx_q;
        s1_ch_d   = s1_ch_q;
        out_vld_d = out_vld_q;
        freq_d    = freq_q;
        ch_d      = ch_q;

        if (flush) begin
            pend_d    = '0;
            ovr_d     = '0;
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end else begin
            if (adv) begin
                out_vld_d = s1_vld_q;
                freq_d    = freq_calc;
                ch_d      = s1_ch_q;
                s1_vld_d  = gnt_any;
                // The grant reads the stored index before this cycle's capture lands.
                s1_idx_d  = idx_q[gnt_idx];
                s1_ch_d   = gnt_idx;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (gnt[k]) begin
                    pend_d[k] = 1'b0;
                end
                if (peak_valid_in[k]) begin
                    pend_d[k] = 1'b1;
                    idx_d[k]  = peak_index_in[k*INDEX_WIDTH +: INDEX_WIDTH];
                    // Losing a request only counts when the old one is not leaving now.
                    if (pend_q[k] && !gnt[k]) begin
                        ovr_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= '0;
            ovr_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                idx_q[k] <= '0;
            end
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_ch_q   <= '0;
            out_vld_q <= 1'b0;
            freq_q    <= '0;
            ch_q      <= '0;
        end else begin
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            idx_q     <= idx_d;
            s1_vld_q  <= s1_vld_d;
            s1_idx_q  <= s1_idx_d;
            s1_ch_q   <= s1_ch_d;
            out_vld_q <= out_vld_d;
            freq_q    <= freq_d;
            ch_q      <= ch_d;
        end
    end

    assign freq_out       = freq_q;
    assign freq_ch_out    = ch_q;
    assign freq_valid_out = out_vld_q;
    assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_peak_freq_arbiter.sv
// Scoreboard bench for peak_freq_arbiter: a reference model pushes expected results,
// a negedge monitor pops them when the DUT presents a new output.
// Directed scenarios first, then randomized traffic with random backpressure and flushes.
module tb_peak_freq_arbiter;

    localparam int NCH   = 4;
    localparam int IW    = 11;
    localparam int FW    = 28;
    localparam int SCALE = (44100 << 12) / 2048;

    logic            clk;
    logic            reset;
    logic            flush;
    logic [NCH-1:0]  peak_valid_in;
    logic [NCH*IW-1:0] peak_index_in;
    logic [FW-1:0]   freq_out;
    logic [1:0]      freq_ch_out;
    logic            freq_valid_out;
    logic            freq_ready_in;
    logic [NCH-1:0]  overrun_out;

    peak_freq_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .peak_valid_in  (peak_valid_in),
        .peak_index_in  (peak_index_in),
        .freq_out       (freq_out),
        .freq_ch_out    (freq_ch_out),
        .freq_valid_out (freq_valid_out),
        .freq_ready_in  (freq_ready_in),
        .overrun_out    (overrun_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [FW-1:0] ref_freq(input int idx);
        longint p;
        p = longint'(idx) * longint'(SCALE);
`ifdef FREQ_ROUND_EN
        p = (p + 2048) >>> 12;
`endif
        return FW'(p);
    endfunction

    function automatic logic [NCH*IW-1:0] pk(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    typedef struct packed {
        logic [1:0]    ch;
        logic [FW-1:0] freq;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: pending slot per channel, round-robin pick among pending,
    // two in-flight slots (operand, output). Updated at every active edge.
    logic           m_pend [NCH];
    int             m_pidx [NCH];
    logic [NCH-1:0] m_ovr;
    int             m_ptr;
    logic           m_s1_v;
    int             m_s1_ch;
    int             m_s1_idx;
    logic           m_out_v;

    initial begin
        logic mv_adv;
        int   g;
        int   c;
        for (int k = 0; k < NCH; k++) begin
            m_pend[k] = 1'b0;
            m_pidx[k] = 0;
        end
        m_ovr = '0; m_ptr = 0; m_s1_v = 1'b0; m_s1_ch = 0; m_s1_idx = 0; m_out_v = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < NCH; k++) m_pend[k] = 1'b0;
                m_ovr = '0; m_ptr = 0; m_s1_v = 1'b0; m_out_v = 1'b0;
                exp_q.delete();
            end else if (flush) begin
                for (int k = 0; k < NCH; k++) m_pend[k] = 1'b0;
                m_ovr = '0; m_s1_v = 1'b0; m_out_v = 1'b0;
                exp_q.delete();
            end else begin
                mv_adv = !m_out_v || freq_ready_in;
                g = -1;
                if (mv_adv) begin
                    for (int i = 0; i < NCH; i++) begin
                        c = (m_ptr + i) % NCH;
                        if (g < 0 && m_pend[c]) g = c;
                    end
                    if (m_s1_v) exp_q.push_back({2'(m_s1_ch), ref_freq(m_s1_idx)});
                    m_out_v = m_s1_v;
                    m_s1_v  = (g >= 0);
                    if (g >= 0) begin
                        m_s1_ch   = g;
                        m_s1_idx  = m_pidx[g];
                        m_pend[g] = 1'b0;
                        m_ptr     = (g + 1) % NCH;
                    end
                end
                for (int k = 0; k < NCH; k++) begin
                    if (peak_valid_in[k]) begin
                        if (m_pend[k]) m_ovr[k] = 1'b1;
                        m_pend[k] = 1'b1;
                        m_pidx[k] = int'(peak_index_in[k*IW +: IW]);
                    end
                end
            end
        end
    end

    // Monitor: a result is new if the previous cycle had no valid or completed a handshake.
    initial begin
        logic          pv;
        logic          pr;
        logic [FW-1:0] lf;
        logic [1:0]    lc;
        exp_t          e;
        pv = 1'b0; pr = 1'b0; lf = '0; lc = '0;
        forever begin
            @(negedge clk);
            chk("valid", 64'(freq_valid_out), 64'(m_out_v));
            chk("overrun", 64'(overrun_out), 64'(m_ovr));
            if (freq_valid_out === 1'b1) begin
                if (!pv || pr) begin
                    chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("freq", 64'(freq_out), 64'(e.freq));
                        chk("ch", 64'(freq_ch_out), 64'(e.ch));
                    end
                end else begin
                    chk("hold_freq", 64'(freq_out), 64'(lf));
                    chk("hold_ch", 64'(freq_ch_out), 64'(lc));
                end
            end
            pv = freq_valid_out; pr = freq_ready_in; lf = freq_out; lc = freq_ch_out;
        end
    end

    task automatic step(input logic [NCH-1:0] v, input logic [NCH*IW-1:0] ix,
                        input logic rdy, input logic fl);
        peak_valid_in = v;
        peak_index_in = ix;
        freq_ready_in = rdy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step('0, '0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; peak_valid_in = '0; peak_index_in = '0; freq_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freq", 64'(freq_out), 64'(0));
        chk("rst_ch", 64'(freq_ch_out), 64'(0));
        chk("rst_valid", 64'(freq_valid_out), 64'(0));
        chk("rst_overrun", 64'(overrun_out), 64'(0));
        reset = 1'b0;

        // Single request, then the largest index.
        step(4'b0001, pk(10, 0, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 4);
        step(4'b0010, pk(0, 2047, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 4);

        // Contention from ptr 0, then a ch0+ch1 pair.
        reset = 1'b1;
        idle(1'b1, 1);
        reset = 1'b0;
        step(4'b1111, pk(1, 2, 3, 4), 1'b1, 1'b0);
        idle(1'b1, 6);
        step(4'b0011, pk(5, 6, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 4);

        // Backpressure: 3 pending held for 5 stalled cycles.
        step(4'b0001, pk(9, 0, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 1);
        step(4'b1110, pk(0, 11, 12, 13), 1'b0, 1'b0);
        idle(1'b0, 5);
        idle(1'b1, 6);

        // Overrun while stalled: ch2 idx 5 replaced by idx 7.
        step(4'b0001, pk(20, 0, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 1);
        step(4'b0100, pk(0, 0, 5, 0), 1'b0, 1'b0);
        step(4'b0100, pk(0, 0, 7, 0), 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("overrun_ch2", 64'(overrun_out[2]), 64'(1));
        idle(1'b1, 6);
        step('0, '0, 1'b1, 1'b1);

        // Capture and grant of ch2 in the same cycle: no overrun.
        step(4'b0100, pk(0, 0, 3, 0), 1'b1, 1'b0);
        step(4'b0100, pk(0, 0, 6, 0), 1'b1, 1'b0);
        idle(1'b1, 4);
        chk("no_overrun_same_cycle", 64'(overrun_out), 64'(0));

        // Flush with valid output and two pending.
        step(4'b0001, pk(8, 0, 0, 0), 1'b1, 1'b0);
        idle(1'b1, 1);
        step(4'b0110, pk(0, 1, 2, 0), 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        chk("flush_valid", 64'(freq_valid_out), 64'(0));
        idle(1'b1, 5);

        // Asynchronous reset mid-burst.
        step(4'b1111, pk(7, 8, 9, 10), 1'b1, 1'b0);
        idle(1'b1, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(freq_valid_out), 64'(0));
        chk("arst_freq", 64'(freq_out), 64'(0));
        chk("arst_ch", 64'(freq_ch_out), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1'b1, 3);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [NCH-1:0] v;
            for (int k = 0; k < NCH; k++) v[k] = ($urandom_range(0, 3) == 0);
            step(v, pk($urandom_range(0, 2047), $urandom_range(0, 2047),
                       $urandom_range(0, 2047), $urandom_range(0, 2047)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        idle(1'b1, 20);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
